alu_sequencer: RTL and testbench

- Upstream control stage for the 8-bit ALU. Accepts one 8085-style arithmetic/logic instruction byte per transaction and decodes it to the 5-bit ALU opcode.
- Sequences the ALU strobes: operand load into TMP, then a single execute pulse.
- Fetches the operand when needed: from the register file, or from memory (M via HL, or the immediate byte via PC) with a request/ready handshake and a timeout.
- Sits between the instruction controller and the ALU. The ALU's data_in is steered by this block's bus_sel.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_seq_decode.sv | 41 ++++
 rtl/alu_sequencer.sv | 118 +++++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control path: ALU opcodes, sequencer state
// encoding, data_in source codes and operand source kinds.
package alu_pkg;

    // ALU opcodes, shared with the ALU itself
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_ADC = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_SBB = 5'b00011;
    localparam logic [4:0] OP_ANA = 5'b00100;
    localparam logic [4:0] OP_XRA = 5'b00101;
    localparam logic [4:0] OP_ORA = 5'b00110;
    localparam logic [4:0] OP_CMP = 5'b00111;
    localparam logic [4:0] OP_RLC = 5'b01000;
    localparam logic [4:0] OP_RRC = 5'b01001;
    localparam logic [4:0] OP_RAL = 5'b01010;
    localparam logic [4:0] OP_RAR = 5'b01011;
    localparam logic [4:0] OP_DAA = 5'b01100;
    localparam logic [4:0] OP_CMA = 5'b01101;
    localparam logic [4:0] OP_STC = 5'b01110;
    localparam logic [4:0] OP_CMC = 5'b01111;
    localparam logic [4:0] OP_INR = 5'b10000;
    localparam logic [4:0] OP_DCR = 5'b10001;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_MEM = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // bus_sel codes; 000-101 match the 8085 sss register field
    localparam logic [2:0] BUS_B   = 3'b000;
    localparam logic [2:0] BUS_C   = 3'b001;
    localparam logic [2:0] BUS_D   = 3'b010;
    localparam logic [2:0] BUS_E   = 3'b011;
    localparam logic [2:0] BUS_H   = 3'b100;
    localparam logic [2:0] BUS_L   = 3'b101;
    localparam logic [2:0] BUS_MEM = 3'b110;
    localparam logic [2:0] BUS_A   = 3'b111;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REG,
        SRC_MEM_M,
        SRC_MEM_IMM
    } src_kind_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of an 8085 arithmetic/logic instruction byte into the
// ALU opcode, the operand source and the register code feeding bus_sel.
module alu_seq_decode
    import alu_pkg::*;
(
    input  logic [7:0] i_instr,
    output logic [4:0] o_opcode,
    output src_kind_e  o_src_kind,
    output logic [2:0] o_reg_code,
    output logic       o_legal
);

    always_comb begin
        o_opcode   = OP_ADD;
        o_src_kind = SRC_NONE;
        o_reg_code = BUS_B;
        o_legal    = 1'b0;
        if (i_instr[7:6] == 2'b10) begin
            // sss = 110 addresses memory through HL rather than a register
            o_opcode   = {2'b00, i_instr[5:3]};
            o_reg_code = i_instr[2:0];
            o_src_kind = (i_instr[2:0] == BUS_MEM) ? SRC_MEM_M : SRC_REG;
            o_legal    = 1'b1;
        end else if (i_instr[7:6] == 2'b11 && i_instr[2:0] == 3'b110) begin
            o_opcode   = {2'b00, i_instr[5:3]};
            o_reg_code = BUS_MEM;
            o_src_kind = SRC_MEM_IMM;
            o_legal    = 1'b1;
        end else if (i_instr[7:6] == 2'b00 && i_instr[2:0] == 3'b111) begin
            o_opcode = {2'b01, i_instr[5:3]};
            o_legal  = 1'b1;
        end else if (i_instr == 8'h3C) begin
            o_opcode = OP_INR;
            o_legal  = 1'b1;
        end else if (i_instr == 8'h3D) begin
            o_opcode = OP_DCR;
            o_legal  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of the 8-bit ALU: decodes one instruction per
// transaction, fetches the operand if needed and strobes TMP load then execute.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] instr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       mem_req,
    output logic       mem_kind,
    input  logic       mem_ready,
    output logic [2:0] bus_sel,
    output logic [4:0] alu_opcode,
    output logic       alu_tmp_write_en,
    output logic       alu_ctrl_sig
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    src_kind_e        r_src;
    logic [2:0]       r_reg_code;
    logic [4:0]       r_opcode;

    logic [4:0] w_opcode;
    src_kind_e  w_src_kind;
    logic [2:0] w_reg_code;
    logic       w_legal;
    logic       w_timeout;
    logic       w_mem_src;

    alu_seq_decode u_decode (
        .i_instr    (instr),
        .o_opcode   (w_opcode),
        .o_src_kind (w_src_kind),
        .o_reg_code (w_reg_code),
        .o_legal    (w_legal)
    );

    // r_cnt holds the number of WAIT_MEM cycles already completed, so the
    // abort fires at the end of the MEM_TIMEOUT-th cycle
    assign w_timeout = (MEM_TIMEOUT > 0) && (r_cnt == CNT_LAST);
    assign w_mem_src = (r_src == SRC_MEM_M) || (r_src == SRC_MEM_IMM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_src      <= SRC_NONE;
            r_reg_code <= BUS_B;
            r_opcode   <= OP_ADD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opcode   <= w_opcode;
                        r_src      <= w_src_kind;
                        r_reg_code <= w_reg_code;
                        r_err      <= !w_legal;
                        r_cnt      <= '0;
                        if (!w_legal) begin
                            r_state <= ST_DONE;
                        end else begin
                            case (w_src_kind)
                                SRC_NONE: r_state <= ST_EXEC;
                                SRC_REG:  r_state <= ST_LOAD;
                                default:  r_state <= ST_WAIT_MEM;
                            endcase
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // data arriving on the last allowed cycle still counts
                    if (mem_ready) begin
                        r_state <= ST_LOAD;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_LOAD: r_state <= ST_EXEC;
                ST_EXEC: r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);
    assign err              = (r_state == ST_DONE) && r_err;
    assign mem_req          = (r_state == ST_WAIT_MEM) || ((r_state == ST_LOAD) && w_mem_src);
    assign mem_kind         = mem_req && (r_src == SRC_MEM_IMM);
    assign alu_opcode       = r_opcode;
    assign alu_tmp_write_en = (r_state == ST_LOAD);
    assign alu_ctrl_sig     = (r_state == ST_EXEC);

    always_comb begin
        bus_sel = BUS_B;
        if (r_state == ST_WAIT_MEM) begin
            bus_sel = BUS_MEM;
        end else if (r_state == ST_LOAD) begin
            bus_sel = r_reg_code;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed scenarios followed by random
// instructions and memory latencies, checked against a transaction-level model.
module tb_alu_sequencer;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       mem_ready = 1'b0;
    logic       busy, done, err, mem_req, mem_kind;
    logic [2:0] bus_sel;
    logic [4:0] alu_opcode;
    logic       alu_tmp_write_en, alu_ctrl_sig;

    alu_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .instr            (instr),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .mem_req          (mem_req),
        .mem_kind         (mem_kind),
        .mem_ready        (mem_ready),
        .bus_sel          (bus_sel),
        .alu_opcode       (alu_opcode),
        .alu_tmp_write_en (alu_tmp_write_en),
        .alu_ctrl_sig     (alu_ctrl_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       err;
        bit [4:0] op;
        bit [2:0] bus;
        int       lat;
        int       n_tmp;
        int       n_ctrl;
        int       n_memreq;
        int       n_kind1;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_done = 0;
    int n_stray = 0;
    int mem_R = 1;
    int mr_cnt = 0;

    int acc_lat, acc_tmp, acc_ctrl, acc_mr, acc_k1;
    logic [4:0] acc_op;
    logic [2:0] acc_bus;

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected transaction outcome from the instruction set rules; R is the
    // WAIT_MEM cycle in which memory first presents data.
    function automatic exp_t model(bit [7:0] b, int R);
        exp_t e;
        int v;
        bit is_mem, is_imm;
        v = int'(b);
        e.err = 1'b0; e.op = 5'd0; e.bus = 3'd0; e.lat = 1;
        e.n_tmp = 0; e.n_ctrl = 0; e.n_memreq = 0; e.n_kind1 = 0;
        is_mem = 1'b0; is_imm = 1'b0;
        if (v >= 'h80 && v < 'hC0) begin
            e.op = 5'((v - 'h80) / 8);
            if (v % 8 == 6) is_mem = 1'b1;
            else begin
                e.bus = 3'(v % 8); e.lat = 3; e.n_tmp = 1; e.n_ctrl = 1;
            end
        end else if (v >= 'hC0 && v % 8 == 6) begin
            e.op = 5'((v - 'hC0) / 8);
            is_mem = 1'b1; is_imm = 1'b1;
        end else if (v < 'h40 && v % 8 == 7) begin
            e.op = 5'(8 + v / 8); e.lat = 2; e.n_ctrl = 1;
        end else if (v == 'h3C) begin
            e.op = 5'd16; e.lat = 2; e.n_ctrl = 1;
        end else if (v == 'h3D) begin
            e.op = 5'd17; e.lat = 2; e.n_ctrl = 1;
        end else begin
            e.err = 1'b1;
        end
        if (is_mem) begin
            if (R <= TO) begin
                e.lat = R + 3; e.n_tmp = 1; e.n_ctrl = 1; e.bus = 3'd6;
                e.n_memreq = R + 1;
            end else begin
                e.err = 1'b1; e.lat = TO + 1; e.n_memreq = TO;
            end
            e.n_kind1 = is_imm ? e.n_memreq : 0;
        end
        return e;
    endfunction

    // Memory: presents data in the mem_R-th request cycle, holds it until mem_req drops
    always @(negedge clk) begin
        if (mem_req) begin
            mr_cnt = mr_cnt + 1;
            mem_ready = (mr_cnt >= mem_R);
        end else begin
            mr_cnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Monitor: gathers one transaction's activity and scores it at done
    always @(negedge clk) begin
        exp_t e;
        if (rst || !busy) begin
            if (!rst && (done || err || alu_tmp_write_en || alu_ctrl_sig || mem_req)) n_stray++;
            acc_lat = 0; acc_tmp = 0; acc_ctrl = 0; acc_mr = 0; acc_k1 = 0;
            acc_op = 5'd0; acc_bus = 3'd0;
        end else begin
            acc_lat++;
            if (alu_tmp_write_en) begin acc_tmp++; acc_bus = bus_sel; end
            if (alu_ctrl_sig) begin acc_ctrl++; acc_op = alu_opcode; end
            if (mem_req) begin acc_mr++; if (mem_kind) acc_k1++; end
            if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("err", int'(err), int'(e.err));
                    chk("latency", acc_lat, e.lat);
                    chk("tmp_writes", acc_tmp, e.n_tmp);
                    chk("exec_pulses", acc_ctrl, e.n_ctrl);
                    chk("mem_req_cycles", acc_mr, e.n_memreq);
                    chk("mem_kind_cycles", acc_k1, e.n_kind1);
                    if (e.n_ctrl > 0) chk("alu_opcode", int'(acc_op), int'(e.op));
                    if (e.n_tmp > 0) chk("bus_sel_load", int'(acc_bus), int'(e.bus));
                end
                acc_lat = 0; acc_tmp = 0; acc_ctrl = 0; acc_mr = 0; acc_k1 = 0;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_wait_expired", 1, 0);
    endtask

    task automatic issue(bit [7:0] b, int R, bit push);
        wait_idle();
        mem_R = R;
        instr = b;
        start = 1'b1;
        if (push) begin
            q.push_back(model(b, R));
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        instr = 8'($urandom);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_mem_req"}, int'(mem_req), 0);
        chk({tag, "_mem_kind"}, int'(mem_kind), 0);
        chk({tag, "_bus_sel"}, int'(bus_sel), 0);
        chk({tag, "_opcode"}, int'(alu_opcode), 0);
        chk({tag, "_tmp_we"}, int'(alu_tmp_write_en), 0);
        chk({tag, "_ctrl"}, int'(alu_ctrl_sig), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] b;
        int r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(8'h80, 1, 1'b1);      // ADD B
        issue(8'h07, 1, 1'b1);      // RLC
        issue(8'hC6, 3, 1'b1);      // ADI, data in 3rd wait cycle
        issue(8'hBE, 100, 1'b1);    // CMP M, memory never answers
        issue(8'hBE, TO, 1'b1);     // data on the timeout cycle itself
        issue(8'h76, 1, 1'b1);      // HLT is not an ALU op

        issue(8'h81, 1, 1'b1);      // ADD C with a second start while busy
        start = 1'b1;
        instr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_start_ignored", int'(busy), 0);

        issue(8'h86, 100, 1'b0);    // ADD M, reset while fetching
        @(negedge clk);
        chk("fetch_mem_req", int'(mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        issue(8'h3C, 1, 1'b1);      // INR A

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: b = 8'h80 | 8'($urandom_range(0, 63));
                1: b = 8'hC6 | 8'($urandom_range(0, 7) << 3);
                2: b = 8'h07 | 8'($urandom_range(0, 7) << 3);
                3: b = ($urandom_range(0, 1) == 0) ? 8'h3C : 8'h3D;
                default: b = 8'($urandom);
            endcase
            r = $urandom_range(1, TO + 2);
            issue(b, r, 1'b1);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", n_done, n_push);
        chk("idle_strobes", n_stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
